// File: rtl/rst_seq_watchdog_if.sv
// ---------------------------------------------------------------------------
// rst_seq_watchdog_if
//   Bundles the run-control requests and status of rst_seq_watchdog.
//   master : the requester side (CPU/IO/bench). It drives rdy_in, halt_req
//            and soft_rst_req, and it observes the status.
//   slave  : the watchdog/sequencer itself.
//   Signals:
//     rdy_in        run-cycle count enable
//     halt_req      program-end strobe
//     soft_rst_req  restart the sequence without top-level reset
//     rst_out       per-domain active-high reset, bit k = domain k
//     run           high while running
//     done          sticky, set when a halt is observed
//     timeout       sticky, set when the watchdog expires
//     cycle_cnt     number of counted run cycles
// ---------------------------------------------------------------------------
interface rst_seq_watchdog_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32
);
    logic              rdy_in;
    logic              halt_req;
    logic              soft_rst_req;
    logic [NUM_CH-1:0] rst_out;
    logic              run;
    logic              done;
    logic              timeout;
    logic [CNT_W-1:0]  cycle_cnt;

    modport master (
        output rdy_in, halt_req, soft_rst_req,
        input  rst_out, run, done, timeout, cycle_cnt
    );

    modport slave (
        input  rdy_in, halt_req, soft_rst_req,
        output rst_out, run, done, timeout, cycle_cnt
    );
endinterface

// File: rtl/rst_seq_watchdog.sv
// ---------------------------------------------------------------------------
// rst_seq_watchdog
//   Multi-channel reset sequencer and run controller. All reset channels are
//   held for HOLD_CYCLES edges after rst falls. The channels are then released
//   in order, STAGGER edges apart. After the last release the block counts run
//   cycles (gated by rdy_in) until a halt request arrives (DONE) or the
//   watchdog expires (TIMEOUT). In TIMEOUT every channel is put back into
//   reset.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset, highest priority
//     bus  rst_seq_watchdog_if.slave (requests in, status out)
//   Every output is registered.
// ---------------------------------------------------------------------------
module rst_seq_watchdog #(
    parameter int              NUM_CH      = 2,
    parameter int              HOLD_CYCLES = 25,
    parameter int              STAGGER     = 4,
    parameter int              CNT_W       = 32,
    parameter longint unsigned TIMEOUT     = 0
) (
    input logic              clk,
    input logic              rst,
    rst_seq_watchdog_if.slave bus
);
    localparam int          LAST_EDGE = HOLD_CYCLES + (NUM_CH - 1) * STAGGER;
    localparam int          SEQ_W     = (LAST_EDGE < 1) ? 1 : $clog2(LAST_EDGE + 1);
    localparam logic [31:0] LAST_U    = 32'(LAST_EDGE);
    localparam logic [31:0] HOLD_U    = 32'(HOLD_CYCLES);
    localparam bit          WDOG_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_M1  = CNT_W'(TIMEOUT - 64'd1);

    // Parameter sanity, reported at elaboration.
    if (NUM_CH < 1) begin : g_chk_ch
        $error("rst_seq_watchdog: NUM_CH must be >= 1");
    end
    if (HOLD_CYCLES < 1) begin : g_chk_hold
        $error("rst_seq_watchdog: HOLD_CYCLES must be >= 1");
    end
    if (CNT_W < 64 && TIMEOUT >= (64'd1 << CNT_W)) begin : g_chk_to
        $error("rst_seq_watchdog: TIMEOUT must be < 2**CNT_W");
    end

    typedef enum logic [2:0] {
        S_HOLD,
        S_RELEASE,
        S_RUN,
        S_DONE,
        S_TMO
    } state_t;

    state_t            state, state_n;
    logic [SEQ_W-1:0]  seq_cnt, seq_n;
    logic [NUM_CH-1:0] rst_out_q, rst_out_n;
    logic              run_q, run_n;
    logic              done_q, done_n;
    logic              to_q, to_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;

    // Edge number this clock edge will complete (seq_cnt counts completed edges).
    logic [31:0]       seq_inc;
    logic [NUM_CH-1:0] rel_due;

    assign seq_inc = 32'(seq_cnt) + 32'd1;

    // Channel k is released from edge HOLD_CYCLES + k*STAGGER onwards.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        localparam logic [31:0] REL_EDGE = 32'(HOLD_CYCLES + k * STAGGER);
        assign rel_due[k] = (seq_inc >= REL_EDGE);
    end

    always_comb begin
        state_n   = state;
        seq_n     = seq_cnt;
        rst_out_n = rst_out_q;
        run_n     = run_q;
        done_n    = done_q;
        to_n      = to_q;
        cnt_n     = cnt_q;
        case (state)
            S_HOLD, S_RELEASE: begin
                // halt_req is ignored while sequencing. rdy_in does not gate
                // the sequence.
                seq_n     = SEQ_W'(seq_inc);
                rst_out_n = ~rel_due;
                if (seq_inc == LAST_U) begin
                    state_n = S_RUN;
                    run_n   = 1'b1;
                end else if (seq_inc >= HOLD_U) begin
                    state_n = S_RELEASE;
                end
            end
            S_RUN: begin
                if (bus.halt_req) begin
                    // A halt beats a watchdog expiry on the same edge. The
                    // count is not incremented on the halt edge.
                    state_n = S_DONE;
                    done_n  = 1'b1;
                    run_n   = 1'b0;
                end else if (bus.rdy_in) begin
                    if (WDOG_EN && cnt_q == TO_M1) begin
                        state_n   = S_TMO;
                        cnt_n     = TO_LIM;
                        to_n      = 1'b1;
                        run_n     = 1'b0;
                        rst_out_n = '1;
                    end else if (cnt_q != '1) begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
            end
            default: ; // DONE and TIMEOUT hold every output until a reset
        endcase
    end

    // A soft reset acts exactly like rst. Channels that are already released
    // go back into reset on the same edge.
    always_ff @(posedge clk) begin
        if (rst || bus.soft_rst_req) begin
            state     <= S_HOLD;
            seq_cnt   <= '0;
            rst_out_q <= '1;
            run_q     <= 1'b0;
            done_q    <= 1'b0;
            to_q      <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state     <= state_n;
            seq_cnt   <= seq_n;
            rst_out_q <= rst_out_n;
            run_q     <= run_n;
            done_q    <= done_n;
            to_q      <= to_n;
            cnt_q     <= cnt_n;
        end
    end

    assign bus.rst_out   = rst_out_q;
    assign bus.run       = run_q;
    assign bus.done      = done_q;
    assign bus.timeout   = to_q;
    assign bus.cycle_cnt = cnt_q;
endmodule

// File: tb/tb_rst_seq_watchdog.sv
// ---------------------------------------------------------------------------
// tb_rst_seq_watchdog
//   Three instances of the design:
//     u0: defaults (2 channels, stagger 4, no watchdog)
//     u1: TIMEOUT=1000
//     u2: 4 channels, STAGGER=0, CNT_W=4 (one-step release, saturation)
//   The stimulus pushes expected snapshots, each tagged with the cycle it
//   applies to. The monitor samples on the falling edge and compares.
// ---------------------------------------------------------------------------
module tb_rst_seq_watchdog;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0] rst_v  = 3'b111;
    logic [2:0] rdy_v  = 3'b111;
    logic [2:0] halt_v = 3'b000;
    logic [2:0] soft_v = 3'b000;

    rst_seq_watchdog_if #(.NUM_CH(2), .CNT_W(32)) i0 ();
    rst_seq_watchdog_if #(.NUM_CH(2), .CNT_W(32)) i1 ();
    rst_seq_watchdog_if #(.NUM_CH(4), .CNT_W(4))  i2 ();

    assign i0.rdy_in = rdy_v[0]; assign i0.halt_req = halt_v[0]; assign i0.soft_rst_req = soft_v[0];
    assign i1.rdy_in = rdy_v[1]; assign i1.halt_req = halt_v[1]; assign i1.soft_rst_req = soft_v[1];
    assign i2.rdy_in = rdy_v[2]; assign i2.halt_req = halt_v[2]; assign i2.soft_rst_req = soft_v[2];

    rst_seq_watchdog u0 (.clk(clk), .rst(rst_v[0]), .bus(i0));
    rst_seq_watchdog #(.TIMEOUT(1000)) u1 (.clk(clk), .rst(rst_v[1]), .bus(i1));
    rst_seq_watchdog #(.NUM_CH(4), .STAGGER(0), .CNT_W(4)) u2 (.clk(clk), .rst(rst_v[2]), .bus(i2));

    // Snapshot layout: {rst_out[3:0], run, done, timeout, cycle_cnt[31:0]}
    typedef struct {
        int          cyc;
        int          d;
        string       nm;
        logic [38:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic push(int d, int c, string nm, logic [3:0] ro, logic r, logic dn,
                        logic to, logic [31:0] cnt);
        exp_t e;
        e.d = d; e.cyc = c; e.nm = nm; e.v = {ro, r, dn, to, cnt};
        sb.push_back(e);
    endtask

    function automatic logic [38:0] obs(int d);
        case (d)
            0:       obs = {2'b00, i0.rst_out, i0.run, i0.done, i0.timeout, i0.cycle_cnt};
            1:       obs = {2'b00, i1.rst_out, i1.run, i1.done, i1.timeout, i1.cycle_cnt};
            default: obs = {i2.rst_out, i2.run, i2.done, i2.timeout, 28'd0, i2.cycle_cnt};
        endcase
    endfunction

    // Monitor: pop every expectation due this cycle and compare it.
    always @(negedge clk) begin
        exp_t        e;
        logic [38:0] a;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            a = obs(e.d);
            checks++;
            if (e.cyc != cyc) begin
                failures++;
                $display("FAIL %s: check slot cyc=%0d missed (now %0d)", e.nm, e.cyc, cyc);
            end else if (a !== e.v) begin
                failures++;
                $display("FAIL %s: dut%0d got rst_out=%h run=%b done=%b to=%b cnt=%0d, want rst_out=%h run=%b done=%b to=%b cnt=%0d",
                         e.nm, e.d, a[38:35], a[34], a[33], a[32], a[31:0],
                         e.v[38:35], e.v[34], e.v[33], e.v[32], e.v[31:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(int c);
        while (cyc < c) tick();
    endtask

    // Hold rst for 25 edges, then drop it. base is the cycle whose next edge is edge 1.
    task automatic start(int d, output int base);
        rst_v[d] = 1'b1;
        repeat (25) tick();
        base     = cyc;
        rst_v[d] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int b;
        // ---------------- u0: release, halt, soft restarts ----------------
        start(0, b);
        push(0, b,       "rst_state",   4'h3, 0, 0, 0, 0);
        push(0, b + 24,  "hold_e24",    4'h3, 0, 0, 0, 0);
        push(0, b + 25,  "rel_ch0_e25", 4'h2, 0, 0, 0, 0);
        push(0, b + 28,  "rel_e28",     4'h2, 0, 0, 0, 0);
        push(0, b + 29,  "run_e29",     4'h0, 1, 0, 0, 0);
        push(0, b + 30,  "cnt_e30",     4'h0, 1, 0, 0, 1);
        push(0, b + 130, "halt_done",   4'h0, 0, 1, 0, 100);
        push(0, b + 180, "done_frozen", 4'h0, 0, 1, 0, 100);
        wait_until(b + 129); halt_v[0] = 1'b1; tick(); halt_v[0] = 1'b0;
        // A second halt while DONE and a stalled rdy_in must both be ignored.
        wait_until(b + 150); halt_v[0] = 1'b1; rdy_v[0] = 1'b0; tick();
        halt_v[0] = 1'b0; rdy_v[0] = 1'b1;
        wait_until(b + 180); soft_v[0] = 1'b1;
        push(0, b + 181, "soft_from_done", 4'h3, 0, 0, 0, 0);
        tick(); soft_v[0] = 1'b0; b = cyc;

        push(0, b + 25, "sr1_rel0",    4'h2, 0, 0, 0, 0);
        push(0, b + 29, "sr1_run",     4'h0, 1, 0, 0, 0);
        push(0, b + 69, "sr1_cnt40",   4'h0, 1, 0, 0, 40);
        push(0, b + 70, "soft_in_run", 4'h3, 0, 0, 0, 0);
        wait_until(b + 69); soft_v[0] = 1'b1; tick(); soft_v[0] = 1'b0; b = cyc;

        push(0, b + 26, "sr2_e26",      4'h2, 0, 0, 0, 0);
        push(0, b + 27, "soft_mid_rel", 4'h3, 0, 0, 0, 0);
        wait_until(b + 26); soft_v[0] = 1'b1; tick(); soft_v[0] = 1'b0; b = cyc;

        push(0, b + 24, "sr3_e24",         4'h3, 0, 0, 0, 0);
        push(0, b + 25, "sr3_e25",         4'h2, 0, 0, 0, 0);
        push(0, b + 29, "sr3_run",         4'h0, 1, 0, 0, 0);
        push(0, b + 40, "sr3_cnt11",       4'h0, 1, 0, 0, 11);
        push(0, b + 41, "soft_beats_halt", 4'h3, 0, 0, 0, 0);
        wait_until(b + 40); soft_v[0] = 1'b1; halt_v[0] = 1'b1; tick();
        soft_v[0] = 1'b0; halt_v[0] = 1'b0;

        // ---------------- u1: watchdog, race, rdy gating ----------------
        start(1, b);
        push(1, b,        "wd_rst",     4'h3, 0, 0, 0, 0);
        push(1, b + 1028, "wd_999",     4'h0, 1, 0, 0, 999);
        push(1, b + 1029, "wd_expire",  4'h3, 0, 0, 1, 1000);
        push(1, b + 1040, "wd_frozen",  4'h3, 0, 0, 1, 1000);
        wait_until(b + 1040); soft_v[1] = 1'b1;
        push(1, b + 1041, "wd_soft_clr", 4'h3, 0, 0, 0, 0);
        tick(); soft_v[1] = 1'b0; b = cyc;

        push(1, b + 1028, "race_999",       4'h0, 1, 0, 0, 999);
        push(1, b + 1029, "race_halt_wins", 4'h0, 0, 1, 0, 999);
        wait_until(b + 1028); halt_v[1] = 1'b1; tick(); halt_v[1] = 1'b0;
        wait_until(b + 1030); soft_v[1] = 1'b1; tick(); soft_v[1] = 1'b0; b = cyc;

        push(1, b + 29,  "gate_run",    4'h0, 1, 0, 0, 0);
        push(1, b + 229, "gate_cnt100", 4'h0, 1, 0, 0, 100);
        wait_until(b + 29);
        for (int i = 0; i < 200; i++) begin
            rdy_v[1] = (i % 2 == 0);
            tick();
        end
        rdy_v[1] = 1'b1;

        // ---------------- u2: one-step release, saturation ----------------
        start(2, b);
        push(2, b,      "p4_rst",     4'hF, 0, 0, 0, 0);
        push(2, b + 24, "p4_hold",    4'hF, 0, 0, 0, 0);
        push(2, b + 25, "p4_all_rel", 4'h0, 1, 0, 0, 0);
        push(2, b + 40, "sat_15",     4'h0, 1, 0, 0, 15);
        push(2, b + 50, "sat_hold",   4'h0, 1, 0, 0, 15);
        wait_until(b + 52);

        tick(); tick();
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            failures++;
            $display("FAIL %s: never checked (slot %0d, now %0d)", e.nm, e.cyc, cyc);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
